// File: rtl/mtr_pkg.sv
// Shared motor-command types and constants for the PWM command decoder.
// The command is an 11-bit two's complement value; the window is one PWM period.
package mtr_pkg;

    typedef logic signed [10:0] mtr_cmd_t;

    localparam int PWM_PERIOD = 1024;
    localparam int CMD_MAX    = 1023;
    localparam int CMD_MIN    = -1024;

    typedef enum logic {
        SETTLE,
        MEASURE
    } state_t;

endpackage

// File: rtl/pwm_cmd_decoder_if.sv
// PWM pair in, recovered command out. The master drives the PWM lines and enable;
// the slave (the decoder) returns cmd with its valid/change pulses and the fault flag.
interface pwm_cmd_decoder_if;
    import mtr_pkg::*;

    logic     en;
    logic     fwd;
    logic     rev;
    mtr_cmd_t cmd;
    logic     cmd_vld;
    logic     cmd_chg;
    logic     fault;

    modport master (
        output en,
        output fwd,
        output rev,
        input  cmd,
        input  cmd_vld,
        input  cmd_chg,
        input  fault
    );

    modport slave (
        input  en,
        input  fwd,
        input  rev,
        output cmd,
        output cmd_vld,
        output cmd_chg,
        output fault
    );

endinterface

// File: rtl/pwm_cmd_decoder_hi_time_cnt.sv
// hi_time_cnt: counts high cycles of one line; o_total includes the current sample.
// Latency: o_total is combinational on i_in; clearing takes effect next cycle. No backpressure.
// Clear has priority so the cycle after a window end always starts from zero.
module hi_time_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_in,
    output logic [CNT_W:0]   o_total
);

    logic [CNT_W:0] r_cnt;

    assign o_total = r_cnt + {{CNT_W{1'b0}}, i_in};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_total;
        end
    end

endmodule

// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder: recovers the signed motor command from a fwd/rev PWM pair, one PERIOD window at a time.
// Latency: cmd/cmd_vld register 1 cycle after the window's last sample; first result 2*PERIOD after start.
// No backpressure: outputs are pulses. PWM_FAULT_DET_EN adds sticky shoot-through detection.
module pwm_cmd_decoder
    import mtr_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_cmd_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0]        L_WIN_LAST = CNT_W'(PERIOD - 1);
    localparam logic signed [CNT_W+1:0] L_MAX      = (CNT_W + 2)'(CMD_MAX);
    localparam logic signed [CNT_W+1:0] L_MIN      = (CNT_W + 2)'(CMD_MIN);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_win_cnt;
    mtr_cmd_t                r_cmd;
    logic                    r_vld;
    logic                    r_chg;

    logic                    w_term;
    logic                    w_clr;
    logic                    w_hold;
    logic [CNT_W:0]          w_fwd_tot;
    logic [CNT_W:0]          w_rev_tot;
    logic signed [CNT_W+1:0] w_diff;
    mtr_cmd_t                w_sat;

    assign w_term = bus.en && (r_win_cnt == L_WIN_LAST);
    assign w_clr  = !bus.en || w_term;

    hi_time_cnt #(.CNT_W(CNT_W)) u_fwd_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_in    (bus.fwd),
        .o_total (w_fwd_tot)
    );

    hi_time_cnt #(.CNT_W(CNT_W)) u_rev_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_in    (bus.rev),
        .o_total (w_rev_tot)
    );

    // A full window of fwd gives +PERIOD, one past the positive range, hence the clamp.
    assign w_diff = $signed({1'b0, w_fwd_tot}) - $signed({1'b0, w_rev_tot});

    always_comb begin
        w_sat = w_diff[$bits(mtr_cmd_t)-1:0];
        if (w_diff > L_MAX) begin
            w_sat = mtr_cmd_t'(CMD_MAX);
        end else if (w_diff < L_MIN) begin
            w_sat = mtr_cmd_t'(CMD_MIN);
        end
    end

`ifdef PWM_FAULT_DET_EN
    logic r_fault;
    logic r_ovl;
    logic w_ovl_now;

    assign w_ovl_now = bus.fwd & bus.rev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
            r_ovl   <= 1'b0;
        end else begin
            if (w_ovl_now) begin
                r_fault <= 1'b1;
            end
            r_ovl <= w_clr ? 1'b0 : (r_ovl | w_ovl_now);
        end
    end

    // The window that saw any overlap is not trusted: it still reports, but keeps the old cmd.
    assign w_hold    = r_ovl | w_ovl_now;
    assign bus.fault = r_fault;
`else
    assign w_hold    = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= SETTLE;
            r_win_cnt <= '0;
            r_cmd     <= '0;
            r_vld     <= 1'b0;
            r_chg     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_chg <= 1'b0;
            if (!bus.en) begin
                r_state   <= SETTLE;
                r_win_cnt <= '0;
            end else if (w_term) begin
                r_win_cnt <= '0;
                if (r_state == SETTLE) begin
                    r_state <= MEASURE;
                end else begin
                    r_vld <= 1'b1;
                    if (!w_hold) begin
                        r_cmd <= w_sat;
                        r_chg <= (w_sat != r_cmd);
                    end
                end
            end else begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cmd     = r_cmd;
    assign bus.cmd_vld = r_vld;
    assign bus.cmd_chg = r_chg;

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// Bench for pwm_cmd_decoder: random PWM stimulus, window-sum reference model, queue scoreboard.
module tb_pwm_cmd_decoder;
    import mtr_pkg::*;

    localparam int P = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_cmd_decoder_if dif();

    pwm_cmd_decoder #(.PERIOD(P), .CNT_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    typedef struct {
        int cmd;
        bit chg;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    // Reference model: samples taken since window start, sums, window index.
    int m_phase = 0, m_win = 0, m_fs = 0, m_rs = 0, m_cmd = 0;
    bit m_ovl = 0, m_fault = 0;

    int lft = 0, ph = 0, t = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void model(input bit rn, input bit e, input bit f, input bit r);
        int d;
        exp_t x;
        if (!rn) begin
            m_phase = 0; m_win = 0; m_fs = 0; m_rs = 0;
            m_ovl = 0; m_cmd = 0; m_fault = 0;
            return;
        end
`ifdef PWM_FAULT_DET_EN
        if (f && r) m_fault = 1;
`endif
        if (!e) begin
            m_phase = 0; m_win = 0; m_fs = 0; m_rs = 0; m_ovl = 0;
            return;
        end
        m_fs += int'(f);
        m_rs += int'(r);
        m_ovl = m_ovl | (f & r);
        if (m_phase == P - 1) begin
            if (m_win > 0) begin
                d = m_fs - m_rs;
                if (d > CMD_MAX) d = CMD_MAX;
                if (d < CMD_MIN) d = CMD_MIN;
                x.due = cyc + 1;
`ifdef PWM_FAULT_DET_EN
                if (m_ovl) d = m_cmd;
`endif
                x.cmd = d;
                x.chg = (d != m_cmd);
                m_cmd = d;
                sbq.push_back(x);
            end
            if (m_win < 2) m_win++;
            m_phase = 0; m_fs = 0; m_rs = 0; m_ovl = 0;
        end else begin
            m_phase++;
        end
    endfunction

    task automatic drive(input bit rn, input bit e, input bit f, input bit r);
        @(negedge clk);
        rst_n   = rn;
        dif.en  = e;
        dif.fwd = f;
        dif.rev = r;
        model(rn, e, f, r);
        t++;
    endtask

    // Motor-controller-like source: |lft| high cycles per period at an arbitrary phase.
    task automatic gen(input int n, input bit e = 1'b1);
        int pos, mag;
        bit hi;
        for (int k = 0; k < n; k++) begin
            pos = (t + ph) % P;
            mag = (lft < 0) ? -lft : lft;
            hi  = (pos < mag);
            drive(1'b1, e, (lft > 0) && hi, (lft < 0) && hi);
        end
    endtask

    task automatic run_const(input int n, input bit f, input bit r);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b1, f, r);
    endtask

    task automatic run_noise(input int n);
        bit f, r;
        for (int k = 0; k < n; k++) begin
            f = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            drive(1'b1, 1'b1, f, r);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bit exp_vld;
        forever begin
            @(posedge clk);
            #1;
            exp_vld = (sbq.size() > 0) && (sbq[0].due == cyc);
            chk("cmd_vld", dif.cmd_vld, exp_vld);
            if (exp_vld) begin
                chk("cmd_chg", dif.cmd_chg, sbq[0].chg);
                chk("vld_cmd", $signed(dif.cmd), sbq[0].cmd);
            end else begin
                chk("cmd_chg_idle", dif.cmd_chg, 0);
            end
            while (sbq.size() > 0 && sbq[0].due <= cyc) sbq.delete(0);
            chk("cmd_hold", $signed(dif.cmd), m_cmd);
            chk("fault", dif.fault, m_fault);
        end
    end

    initial begin
        rst_n   = 1'b0;
        dif.en  = 1'b0;
        dif.fwd = 1'b0;
        dif.rev = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_cmd", $signed(dif.cmd), 0);
        chk("rst_vld", dif.cmd_vld, 0);
        chk("rst_fault", dif.fault, 0);

        lft = 63; ph = int'($urandom_range(0, P - 1));
        gen(3 * P + 100);
        chk("cmd_03f", $signed(dif.cmd), 63);

        lft = -14;
        gen(3 * P);
        chk("cmd_7f2", $signed(dif.cmd), -14);

        repeat (4) begin
            lft = int'($urandom_range(0, 2047)) - 1024;
            ph  = int'($urandom_range(0, P - 1));
            gen(2 * P + int'($urandom_range(0, 400)));
        end

        run_const(3 * P, 1'b1, 1'b0);
        chk("fwd_stuck", $signed(dif.cmd), 1023);
        run_const(3 * P, 1'b0, 1'b1);
        chk("rev_stuck", $signed(dif.cmd), -1024);
        run_const(2 * P + 10, 1'b0, 1'b0);
        chk("both_low", $signed(dif.cmd), 0);

        lft = 200;
        gen(P + int'($urandom_range(100, 600)));
        gen(300, 1'b0);
        gen(2 * P + 50);

        lft = -377;
        for (int k = 0; k < 2 * P && m_phase != 500; k++) gen(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        gen(1);
        chk("rstpulse_cmd", $signed(dif.cmd), 0);
        chk("rstpulse_vld", dif.cmd_vld, 0);
        gen(2 * P + 50);

        lft = 300;
        gen(P + int'($urandom_range(100, 800)));
        run_const(3, 1'b1, 1'b1);
        gen(2 * P + 20);
`ifdef PWM_FAULT_DET_EN
        chk("fault_sticky", dif.fault, 1);
`else
        chk("fault_tied", dif.fault, 0);
`endif

        run_noise(2 * P + 30);
        lft = 511;
        gen(2 * P + 20);

        repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
